// File: rtl/chacha_round_ctrl.sv
// Sequencer for a ChaCha block core: runs LOAD, ROUNDS rounds, feed-forward ADD and an OUT
// handshake for each block of a run, stepping the block counter between blocks.
module chacha_round_ctrl #(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned CTR_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       nblocks,
  input  logic [CTR_W-1:0] ctr_init,
  input  logic             out_ready,
  output logic             busy,
  output logic             load_state,
  output logic [CTR_W-1:0] blk_ctr,
  output logic             round_en,
  output logic             diag,
  output logic [4:0]       round_idx,
  output logic             add_en,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StAdd,
    StOut,
    StFin
  } state_e;

  localparam logic [4:0] LastIdx = 5'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [7:0]       remain_q, remain_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [4:0]       idx_q, idx_d;

  logic busy_q, load_q, round_q, add_q, valid_q, done_q;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ctr_d    = ctr_q;
    idx_d    = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start && (nblocks != 8'd0)) begin
          state_d  = StLoad;
          remain_d = nblocks;
          ctr_d    = ctr_init;
        end
      end
      StLoad: begin
        state_d = StRound;
        idx_d   = '0;
      end
      StRound: begin
        if (idx_q == LastIdx) begin
          state_d = StAdd;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      StAdd: state_d = StOut;
      StOut: begin
        if (out_ready) begin
          if (remain_q > 8'd1) begin
            state_d  = StLoad;
            remain_d = remain_q - 8'd1;
            // Counter wraps silently at 2^CTR_W.
            ctr_d    = ctr_q + CTR_W'(1);
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      remain_q <= '0;
      ctr_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      round_q  <= 1'b0;
      add_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ctr_q    <= ctr_d;
      idx_q    <= idx_d;
      busy_q   <= (state_d != StIdle);
      load_q   <= (state_d == StLoad);
      round_q  <= (state_d == StRound);
      add_q    <= (state_d == StAdd);
      valid_q  <= (state_d == StOut);
      done_q   <= (state_d == StFin);
    end
  end

  assign busy       = busy_q;
  assign load_state = load_q;
  assign round_en   = round_q;
  assign add_en     = add_q;
  assign out_valid  = valid_q;
  assign done       = done_q;
  assign blk_ctr    = ctr_q;
  assign round_idx  = idx_q;
  assign diag       = idx_q[0];

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Scoreboard bench for chacha_round_ctrl: stimulus pushes expected block counters and done
// tokens, a negedge monitor checks every cycle against them and the round-sequencing rules.
module tb_chacha_round_ctrl;

  localparam int unsigned ROUNDS = 20;
  localparam int unsigned CTR_W  = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       nblocks = '0;
  logic [CTR_W-1:0] ctr_init = '0;
  logic             out_ready = 1'b0;
  logic             busy, load_state, round_en, diag, add_en, out_valid, done;
  logic [CTR_W-1:0] blk_ctr;
  logic [4:0]       round_idx;

  chacha_round_ctrl #(
    .ROUNDS(ROUNDS),
    .CTR_W (CTR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .nblocks   (nblocks),
    .ctr_init  (ctr_init),
    .out_ready (out_ready),
    .busy      (busy),
    .load_state(load_state),
    .blk_ctr   (blk_ctr),
    .round_en  (round_en),
    .diag      (diag),
    .round_idx (round_idx),
    .add_en    (add_en),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: counters of blocks still to be delivered, and pending done pulses.
  logic [CTR_W-1:0] exp_ctr_q[$];
  int               exp_done = 0;
  bit               rand_rdy = 1'b0;

  logic [4:0] flags;
  assign flags = {load_state, round_en, add_en, out_valid, done};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic model_run(input int n, input logic [CTR_W-1:0] c);
    logic [CTR_W-1:0] v;
    v = c;
    for (int i = 0; i < n; i++) begin
      exp_ctr_q.push_back(v);
      v = v + 1'b1;
    end
    exp_done++;
  endtask

  task automatic start_run(input int n, input logic [CTR_W-1:0] c);
    tick();
    model_run(n, c);
    start    = 1'b1;
    nblocks  = 8'(n);
    ctr_init = c;
    tick();
    start = 1'b0;
  endtask

  // sel: 0 = done, 1 = out_valid, 2 = round_idx 9 in ROUND. Returns at a negedge.
  task automatic wait_cond(input int sel, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      case (sel)
        0:       hit = done;
        1:       hit = out_valid;
        default: hit = round_en && (round_idx == 5'd9);
      endcase
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL timeout_%s: not seen within %0d cycles, expected seen", name, budget);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, {busy, flags, diag, round_idx}, '0);
    chk({tag, "_blk_ctr"}, blk_ctr, '0);
  endtask

  always @(posedge clock) begin
    #3;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  int rcnt    = 0;
  bit ov_wait = 1'b0;

  // Monitor: per-cycle protocol rules plus scoreboard pops on each OUT transfer.
  always @(negedge clock) begin
    if (reset) begin
      rcnt    = 0;
      ov_wait = 1'b0;
    end else begin
      chk("one_hot_strobes", 64'($countones(flags) <= 1), 64'd1);
      chk("busy_vs_state", busy, |flags);
      if (ov_wait) chk("out_valid_held", out_valid, 1'b1);
      if (load_state) rcnt = 0;
      if (round_en) begin
        chk("round_idx", round_idx, 64'(rcnt));
        chk("diag", diag, 64'(rcnt % 2));
        rcnt++;
      end
      if (add_en) chk("rounds_per_block", 64'(rcnt), 64'(ROUNDS));
      if (load_state || round_en || add_en || out_valid) begin
        if (exp_ctr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_block: blk_ctr %0h active, expected no block", blk_ctr);
        end else begin
          chk("blk_ctr", blk_ctr, exp_ctr_q[0]);
          if (out_valid && out_ready) void'(exp_ctr_q.pop_front());
        end
      end
      if (done) begin
        chk("done_expected", 64'((exp_done > 0) && (exp_ctr_q.size() == 0)), 64'd1);
        if (exp_done > 0) exp_done--;
      end
      ov_wait = out_valid && !out_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_cnt;
    logic [4:0] exp_flags;

    repeat (3) tick();
    @(negedge clock);
    chk_reset_vals("reset_init");
    tick();
    reset = 1'b0;

    // Single block timing, counter 7, ready always high.
    out_ready = 1'b1;
    tick();
    model_run(1, 32'd7);
    start    = 1'b1;
    nblocks  = 8'd1;
    ctr_init = 32'd7;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      exp_flags = (k == 1) ? 5'b10000 : (k <= 21) ? 5'b01000 : (k == 22) ? 5'b00100 :
                  (k == 23) ? 5'b00010 : (k == 24) ? 5'b00001 : 5'b00000;
      chk($sformatf("single_flags_c%0d", k), flags, exp_flags);
      chk($sformatf("single_busy_c%0d", k), busy, (k <= 24));
      if (k >= 2 && k <= 21) chk($sformatf("single_diag_c%0d", k), diag, 64'((k - 2) % 2));
      if (k == 23) chk("single_blk_ctr", blk_ctr, 32'd7);
    end

    // Backpressure: ready low for 5 cycles of out_valid, then one transfer cycle.
    tick();
    out_ready = 1'b0;
    start_run(2, 32'd7);
    wait_cond(1, 100, "first_out_valid");
    ov_cnt = 1;
    repeat (4) begin
      tick();
      @(negedge clock);
      if (out_valid) ov_cnt++;
    end
    tick();
    out_ready = 1'b1;
    @(negedge clock);
    if (out_valid) ov_cnt++;
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    chk("bp_out_valid_cycles", 64'(ov_cnt), 64'd6);
    chk("bp_second_load", load_state, 1'b1);
    chk("bp_second_ctr", blk_ctr, 32'd8);
    tick();
    out_ready = 1'b1;
    wait_cond(0, 200, "bp_done");
    repeat (5) @(negedge clock);

    // Counter wrap across a two-block run.
    start_run(2, 32'hFFFF_FFFF);
    wait_cond(0, 200, "wrap_done");

    // Start in the FIN cycle is ignored.
    #1;
    start    = 1'b1;
    nblocks  = 8'd1;
    ctr_init = 32'd55;
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("fin_start_ignored", busy, 1'b0);

    // Start with nblocks = 0 is ignored.
    tick();
    start   = 1'b1;
    nblocks = 8'd0;
    tick();
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("zero_blocks_idle", busy, 1'b0);
    end

    // Start pulsed mid-ROUND is ignored.
    start_run(1, 32'd100);
    wait_cond(2, 100, "idx9_a");
    #1;
    start    = 1'b1;
    nblocks  = 8'd3;
    ctr_init = 32'h1234;
    tick();
    start = 1'b0;
    wait_cond(0, 200, "midstart_done");

    // Reset at round 9 abandons the run.
    start_run(1, 32'h40);
    wait_cond(2, 100, "idx9_b");
    #1;
    reset = 1'b1;
    exp_ctr_q.delete();
    exp_done = 0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("reset_mid");
    repeat (4) begin
      @(negedge clock);
      chk("no_done_after_reset", done, 1'b0);
    end
    start_run(1, 32'h41);
    wait_cond(0, 200, "post_reset_done");

    // Start held through reset release is taken on the first non-reset edge.
    tick();
    reset    = 1'b1;
    start    = 1'b1;
    nblocks  = 8'd1;
    ctr_init = 32'd5;
    tick();
    tick();
    model_run(1, 32'd5);
    reset = 1'b0;
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("start_through_reset", load_state, 1'b1);
    wait_cond(0, 200, "rst_start_done");

    // Randomized runs with random backpressure and stray starts while busy.
    rand_rdy = 1'b1;
    for (int r = 0; r < 8; r++) begin
      logic [CTR_W-1:0] c;
      int n;
      n = $urandom_range(1, 4);
      c = (r == 2) ? 32'hFFFF_FFFE : $urandom;
      start_run(n, c);
      repeat ($urandom_range(1, 17)) tick();
      start    = 1'b1;
      nblocks  = 8'($urandom_range(0, 255));
      ctr_init = $urandom;
      tick();
      start = 1'b0;
      wait_cond(0, 2000, "rand_done");
    end
    rand_rdy = 1'b0;
    repeat (5) tick();

    chk("scoreboard_blocks_left", 64'(exp_ctr_q.size()), 64'd0);
    chk("scoreboard_done_left", 64'(exp_done), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
